// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// No ports. Provides:
//   RF_XLEN    - default data width of the RV32 register file
//   REG_ZERO   - index of the hardwired-zero register x0
//   wb_req_t   - one writeback request {rdi, rd}
//   wb_entry_t - one queued MUL/DIV writeback {kill, rdi, rd}
//   reg_onehot - one-hot decode of a register index
package rf_arb_pkg;

    localparam int         RF_XLEN  = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]         rdi;
        logic [RF_XLEN-1:0] rd;
    } wb_req_t;

    typedef struct packed {
        logic               kill;
        logic [4:0]         rdi;
        logic [RF_XLEN-1:0] rd;
    } wb_entry_t;

    function automatic logic [31:0] reg_onehot(input logic [4:0] idx);
        reg_onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback sources, the arbiter and the register file.
// slave  : the arbiter side (takes ALU/MD requests, drives the RF write port).
// master : the environment side (ALU writeback, MUL/DIV unit, RF, decode).
// Signals:
//   alu_valid/alu_rdi/alu_rd  ALU writeback request, alu_stall back-pressure
//   md_valid/md_rdi/md_rd     MUL/DIV result, md_ready back-pressure
//   rdi/rd/write_enable       register file write port (registered)
//   pending                   per-register outstanding MUL/DIV write mask
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rdi;
    logic [XLEN-1:0] alu_rd;
    logic            alu_stall;

    logic            md_valid;
    logic            md_ready;
    logic [4:0]      md_rdi;
    logic [XLEN-1:0] md_rd;

    logic [4:0]      rdi;
    logic [XLEN-1:0] rd;
    logic            write_enable;
    logic [31:0]     pending;

    modport slave (
        input  alu_valid, alu_rdi, alu_rd, md_valid, md_rdi, md_rd,
        output alu_stall, md_ready, rdi, rd, write_enable, pending
    );

    modport master (
        output alu_valid, alu_rdi, alu_rd, md_valid, md_rdi, md_rd,
        input  alu_stall, md_ready, rdi, rd, write_enable, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: in-order queue of MUL/DIV writebacks with per-entry kill bits.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push_i/_rdi_i/_rd_i enqueue one entry (caller guarantees not full)
//   pop_i               drop the head entry (caller guarantees not empty)
//   squash_i/_rdi_i     mark every queued entry targeting squash_rdi_i as killed
//   head_*_o            head entry contents; head_valid_o = queue not empty
//   full_o              count == DEPTH
//   live_mask_o         OR of one-hot rdi over queued, non-killed entries
module wb_fifo
    import rf_arb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic [4:0]      push_rdi_i,
    input  logic [XLEN-1:0] push_rd_i,
    input  logic            pop_i,
    input  logic            squash_i,
    input  logic [4:0]      squash_rdi_i,
    output logic            head_valid_o,
    output logic            head_kill_o,
    output logic [4:0]      head_rdi_o,
    output logic [XLEN-1:0] head_rd_o,
    output logic            full_o,
    output logic [31:0]     live_mask_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [4:0]       rdi_q [DEPTH];
    logic [XLEN-1:0]  rd_q  [DEPTH];
    logic [DEPTH-1:0] kill_q;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // Slot i is occupied when its distance from head (mod DEPTH) is below count.
    always_comb begin
        occ         = '0;
        live_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ((i + DEPTH - int'(head_q)) % DEPTH) < int'(count_q);
            if (occ[i] && !kill_q[i]) begin
                live_mask_o = live_mask_o | reg_onehot(rdi_q[i]);
            end
        end
        live_mask_o[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            kill_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_i && occ[i] && rdi_q[i] == squash_rdi_i) begin
                    kill_q[i] <= 1'b1;
                end
            end
            // The pushed slot is never occupied, so the squash above cannot hit it.
            if (push_i) begin
                rdi_q[tail_q]  <= push_rdi_i;
                rd_q[tail_q]   <= push_rd_i;
                kill_q[tail_q] <= 1'b0;
                tail_q         <= ptr_inc(tail_q);
            end
            if (pop_i) begin
                head_q <= ptr_inc(head_q);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_kill_o  = kill_q[head_q];
    assign head_rdi_o   = rdi_q[head_q];
    assign head_rd_o    = rd_q[head_q];
    assign full_o       = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the RV32IM register-file write port between the
// single-cycle ALU writeback and queued MUL/DIV results.
// Ports:
//   clk  clock (rising edge)
//   rst  synchronous active-high reset
//   bus  regfile_wb_arbiter_if.slave - ALU/MD requests in, RF write port,
//        alu_stall, md_ready and pending mask out
module regfile_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic                   clk,
    input logic                   rst,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1) > 0 ? $clog2(STARVE_LIMIT + 1) : 1;

    logic            head_valid, head_kill, full;
    logic [4:0]      head_rdi;
    logic [XLEN-1:0] head_rd;
    logic [31:0]     live_mask;

    logic            head_live, alu_wr, starve;
    logic            grant_alu, grant_md, pop, push, alu_stall;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            we_q, we_d;
    logic [4:0]      rdi_q, rdi_d;
    logic [XLEN-1:0] rd_q, rd_d;

    wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_rdi_i   (bus.md_rdi),
        .push_rd_i    (bus.md_rd),
        .pop_i        (pop),
        .squash_i     (grant_alu),
        .squash_rdi_i (bus.alu_rdi),
        .head_valid_o (head_valid),
        .head_kill_o  (head_kill),
        .head_rdi_o   (head_rdi),
        .head_rd_o    (head_rd),
        .full_o       (full),
        .live_mask_o  (live_mask)
    );

    always_comb begin
        head_live  = head_valid && !head_kill;
        // An ALU write to x0 is accepted without using the port.
        alu_wr     = bus.alu_valid && (bus.alu_rdi != REG_ZERO);
        starve     = head_live && (wait_cnt_q == WAIT_W'(STARVE_LIMIT));
        grant_alu  = 1'b0;
        grant_md   = 1'b0;
        alu_stall  = 1'b0;
        if (starve) begin
            grant_md  = 1'b1;
            alu_stall = alu_wr;
        end else if (alu_wr) begin
            grant_alu = 1'b1;
        end else if (head_live) begin
            grant_md = 1'b1;
        end

        // Killed heads leave for free, independent of who owns the port.
        pop  = grant_md || (head_valid && head_kill);
        push = bus.md_valid && !full && (bus.md_rdi != REG_ZERO);

        // A killed head neither advances nor clears the starvation count.
        wait_cnt_d = wait_cnt_q;
        if (!head_valid || grant_md) begin
            wait_cnt_d = '0;
        end else if (head_live && wait_cnt_q != WAIT_W'(STARVE_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        we_d  = grant_alu || grant_md;
        rdi_d = rdi_q;
        rd_d  = rd_q;
        if (grant_alu) begin
            rdi_d = bus.alu_rdi;
            rd_d  = bus.alu_rd;
        end else if (grant_md) begin
            rdi_d = head_rdi;
            rd_d  = head_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            rdi_q      <= '0;
            rd_q       <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            rdi_q      <= rdi_d;
            rd_q       <= rd_d;
        end
    end

    assign bus.alu_stall    = alu_stall;
    assign bus.md_ready     = !full;
    assign bus.rdi          = rdi_q;
    assign bus.rd           = rd_q;
    assign bus.write_enable = we_q;
    assign bus.pending      = live_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import rf_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(32)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Register file model fed by the DUT write port, plus per-register write counts.
    logic [31:0] rf_model [32] = '{default: 32'h0};
    int          wr_cnt   [32] = '{default: 0};
    always @(posedge clk) begin
        if (bus.write_enable) begin
            rf_model[bus.rdi] <= bus.rd;
            wr_cnt[bus.rdi]   <= wr_cnt[bus.rdi] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    wb_req_t req;

    initial begin
        rst           = 1'b1;
        bus.alu_valid = 1'b0;
        bus.alu_rdi   = 5'd0;
        bus.alu_rd    = 32'h0;
        bus.md_valid  = 1'b0;
        bus.md_rdi    = 5'd0;
        bus.md_rd     = 32'h0;
        repeat (2) tick();

        chk("rst_we",      64'(bus.write_enable), 64'd0);
        chk("rst_rdi",     64'(bus.rdi),          64'd0);
        chk("rst_rd",      64'(bus.rd),           64'd0);
        chk("rst_stall",   64'(bus.alu_stall),    64'd0);
        chk("rst_ready",   64'(bus.md_ready),     64'd1);
        chk("rst_pending", 64'(bus.pending),      64'd0);
        rst = 1'b0;
        tick();

        // ALU only: x4 = 0x12345
        bus.alu_valid = 1'b1; bus.alu_rdi = 5'd4; bus.alu_rd = 32'h12345;
        #1 chk("alu_stall", 64'(bus.alu_stall), 64'd0);
        tick();
        chk("alu_we",  64'(bus.write_enable), 64'd1);
        chk("alu_rdi", 64'(bus.rdi),          64'd4);
        chk("alu_rd",  64'(bus.rd),           64'h12345);
        bus.alu_valid = 1'b0;
        tick();
        chk("alu_we_low",   64'(bus.write_enable), 64'd0);
        chk("alu_rdi_hold", 64'(bus.rdi),          64'd4);
        chk("alu_rd_hold",  64'(bus.rd),           64'h12345);
        chk("alu_readback", 64'(rf_model[4]),      64'h12345);

        // Starvation: MD x3 = 0x98765 under continuous ALU x10 traffic
        req = '{rdi: 5'd3, rd: 32'h98765};
        bus.alu_valid = 1'b1; bus.alu_rdi = 5'd10; bus.alu_rd = 32'hA0;
        bus.md_valid  = 1'b1; bus.md_rdi  = req.rdi; bus.md_rd = req.rd;
        #1 chk("starve_ready", 64'(bus.md_ready), 64'd1);
        tick();
        bus.md_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.alu_rd = 32'hA0 + 32'(k);
            #1;
            chk("starve_no_stall", 64'(bus.alu_stall),  64'd0);
            chk("starve_pend3",    64'(bus.pending[3]), 64'd1);
            tick();
            chk("starve_alu_we",  64'(bus.write_enable), 64'd1);
            chk("starve_alu_rdi", 64'(bus.rdi),          64'd10);
            chk("starve_alu_rd",  64'(bus.rd),           64'hA0 + 64'(k));
        end
        #1 chk("starve_stall", 64'(bus.alu_stall), 64'd1);
        tick();
        chk("starve_md_we",  64'(bus.write_enable), 64'd1);
        chk("starve_md_rdi", 64'(bus.rdi),          64'd3);
        chk("starve_md_rd",  64'(bus.rd),           64'h98765);
        chk("starve_pend_clr", 64'(bus.pending),    64'd0);
        chk("starve_unstall",  64'(bus.alu_stall),  64'd0);
        tick();
        chk("starve_held_alu_rdi", 64'(bus.rdi), 64'd10);
        chk("starve_held_alu_rd",  64'(bus.rd),  64'hA3);
        bus.alu_valid = 1'b0;
        tick();
        chk("starve_idle_we", 64'(bus.write_enable), 64'd0);

        // Squash: MD x5 = 0xAAAA queued, then ALU x5 = 0xBBBB
        bus.md_valid = 1'b1; bus.md_rdi = 5'd5; bus.md_rd = 32'hAAAA;
        tick();
        bus.md_valid  = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rdi = 5'd5; bus.alu_rd = 32'hBBBB;
        #1 chk("squash_pend_set", 64'(bus.pending[5]), 64'd1);
        tick();
        bus.alu_valid = 1'b0;
        chk("squash_we",  64'(bus.write_enable), 64'd1);
        chk("squash_rd",  64'(bus.rd),           64'hBBBB);
        chk("squash_pend_clr", 64'(bus.pending[5]), 64'd0);
        tick();
        chk("squash_silent", 64'(bus.write_enable), 64'd0);
        tick();
        chk("squash_count", 64'(wr_cnt[5]),   64'd1);
        chk("squash_final", 64'(rf_model[5]), 64'hBBBB);
        chk("squash_empty", 64'(bus.md_ready), 64'd1);

        // Full queue / back-pressure with DEPTH=2
        bus.alu_valid = 1'b1; bus.alu_rdi = 5'd10; bus.alu_rd = 32'hC0;
        bus.md_valid  = 1'b1; bus.md_rdi  = 5'd6;  bus.md_rd  = 32'h6666;
        #1 chk("full_ready0", 64'(bus.md_ready), 64'd1);
        tick();
        bus.md_rdi = 5'd7; bus.md_rd = 32'h7777;
        #1 chk("full_ready1", 64'(bus.md_ready), 64'd1);
        tick();
        bus.md_rdi = 5'd8; bus.md_rd = 32'h8888;
        #1;
        chk("full_ready_low", 64'(bus.md_ready), 64'd0);
        chk("full_pending",   64'(bus.pending),  64'h0000_00C0);
        tick();
        tick();
        tick();
        chk("full_stall",          64'(bus.alu_stall), 64'd1);
        chk("full_ready_pop_cyc",  64'(bus.md_ready),  64'd0);
        tick();
        chk("full_w1_rdi", 64'(bus.rdi), 64'd6);
        chk("full_w1_rd",  64'(bus.rd),  64'h6666);
        chk("full_ready_back", 64'(bus.md_ready),  64'd1);
        chk("full_unstall",    64'(bus.alu_stall), 64'd0);
        tick();
        chk("full_alu_rdi", 64'(bus.rdi),     64'd10);
        chk("full_pend2",   64'(bus.pending), 64'h0000_0180);
        bus.md_valid  = 1'b0;
        bus.alu_valid = 1'b0;
        tick();
        chk("full_w2_rdi", 64'(bus.rdi), 64'd7);
        chk("full_w2_rd",  64'(bus.rd),  64'h7777);
        tick();
        chk("full_w3_we",  64'(bus.write_enable), 64'd1);
        chk("full_w3_rdi", 64'(bus.rdi), 64'd8);
        chk("full_w3_rd",  64'(bus.rd),  64'h8888);
        tick();
        chk("full_done_we",   64'(bus.write_enable), 64'd0);
        chk("full_done_pend", 64'(bus.pending),      64'd0);

        // x0 filtering
        bus.alu_valid = 1'b1; bus.alu_rdi = 5'd0; bus.alu_rd = 32'hDEAD;
        bus.md_valid  = 1'b1; bus.md_rdi  = 5'd0; bus.md_rd  = 32'hBEEF;
        #1;
        chk("x0_stall", 64'(bus.alu_stall), 64'd0);
        chk("x0_ready", 64'(bus.md_ready),  64'd1);
        tick();
        bus.alu_valid = 1'b0;
        bus.md_valid  = 1'b0;
        chk("x0_we",      64'(bus.write_enable), 64'd0);
        chk("x0_pending", 64'(bus.pending),      64'd0);
        chk("x0_ready2",  64'(bus.md_ready),     64'd1);
        tick();
        chk("x0_we2",  64'(bus.write_enable), 64'd0);
        chk("x0_wcnt", 64'(wr_cnt[0]),        64'd0);

        // Reset with two entries queued
        bus.alu_valid = 1'b1; bus.alu_rdi = 5'd10; bus.alu_rd = 32'hE0;
        bus.md_valid  = 1'b1; bus.md_rdi  = 5'd9;  bus.md_rd  = 32'h9999;
        tick();
        bus.md_rdi = 5'd11; bus.md_rd = 32'hBBB1;
        tick();
        bus.md_valid  = 1'b0;
        bus.alu_valid = 1'b0;
        #1;
        chk("rstq_full",    64'(bus.md_ready), 64'd0);
        chk("rstq_pending", 64'(bus.pending),  64'h0000_0A00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstq_we",      64'(bus.write_enable), 64'd0);
        chk("rstq_rdi",     64'(bus.rdi),          64'd0);
        chk("rstq_rd",      64'(bus.rd),           64'd0);
        chk("rstq_stall",   64'(bus.alu_stall),    64'd0);
        chk("rstq_ready",   64'(bus.md_ready),     64'd1);
        chk("rstq_pending", 64'(bus.pending),      64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rstq_no_write", 64'(bus.write_enable), 64'd0);
        end
        chk("rstq_x9",  64'(wr_cnt[9]),  64'd0);
        chk("rstq_x11", 64'(wr_cnt[11]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the RV32IM register file between the single-cycle ALU writeback path and the multi-cycle MUL/DIV unit. MUL/DIV results are buffered in a small in-order queue. ALU writes normally win the port, and a starvation counter forces queued MUL/DIV writes to drain. The block drives the register file's `rdi`/`rd`/`write_enable` from registered outputs and exports a per-register pending mask for decode-stage hazard detection.

## Interface
Parameters:
- `XLEN`, 32, data width
- `DEPTH`, 2, MUL/DIV result queue entries (≥1)
- `STARVE_LIMIT`, 4, consecutive cycles a non-killed queue head may lose arbitration before the ALU is stalled

Ports:
- `clk`  in  1  clock; everything is on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `alu_valid`  in  1  ALU writeback request this cycle
- `alu_rdi`  in  5  ALU destination index
- `alu_rd`  in  XLEN  ALU write data
- `alu_stall`  out  1  combinational; ALU request not accepted this cycle, pipeline holds
- `md_valid`  in  1  MUL/DIV result valid
- `md_ready`  out  1  queue can accept; transfer on `md_valid && md_ready`
- `md_rdi`  in  5  MUL/DIV destination index
- `md_rd`  in  XLEN  MUL/DIV result
- `rdi`  out  5  register file write index (registered)
- `rd`  out  XLEN  register file write data (registered)
- `write_enable`  out  1  register file write strobe (registered)
- `pending`  out  32  bit i set while a live queued MUL/DIV write targets xi; bit 0 always 0

## Operation
- **x0 filtering:** requests with `rdi == 0` are accepted but never written. An ALU x0 request is granted trivially with no port use. An MD x0 request is acknowledged and not enqueued.
- **Queue:** a FIFO of {rdi, rd, kill} entries, in MD acceptance order. `md_ready = (count < DEPTH)` from registered state. There is no same-cycle pass-through.
- **Squash:** the ALU write is younger in program order. When an ALU write to xi (i≠0) is granted, set `kill` on every queued entry with rdi == i. A new MD entry accepted in the same cycle is not killed.
- **Killed head:** a killed head pops in any cycle at no port cost. It does not advance or reset the starvation counter.
- **Arbitration priority each cycle:**
  - (1) If the head is live and `wait_cnt == STARVE_LIMIT`: grant the head and set `alu_stall = alu_valid`.
  - (2) Else, if `alu_valid`: grant the ALU and set `alu_stall = 0`.
  - (3) Else, if the head is live: grant the head.
  - (4) Else: no grant.
- **wait_cnt:** increments while the head is live and not granted, saturating at `STARVE_LIMIT`. It resets to 0 on a head pop or when the queue is empty.
- **Outputs:** on a grant, `write_enable <= 1` and `rdi`/`rd` take the granted values. With no grant, `write_enable <= 0` and `rdi`/`rd` hold.
- **Pending mask:** `pending` is the OR over live queue entries of the one-hot rdi. A granted head clears its bit the same cycle, unless another live entry targets the same register.

## Timing
- **Reset values:** `write_enable = 0`, `rdi = 0`, `rd = 0`, `alu_stall = 0`, `md_ready = 1`, `pending = 0`, queue empty, `wait_cnt = 0`.
- **ALU latency:** ALU granted in cycle N gives `write_enable` high in cycle N+1. The register file commits at the end of N+1.
- **MD latency:** MD accepted in cycle N makes the head visible in N+1. Earliest `write_enable` is in N+2.
- **Full queue:** when the queue is full, `md_ready = 0`. A pop in the same cycle does not raise `md_ready` until the next cycle.
- **Simultaneous events:** ALU grant, MD enqueue and killed-head pop can all occur in one cycle. A head pop and an enqueue in the same cycle keep `count` unchanged.
- **Reset mid-operation:** `rst` high at an edge discards all queued entries, including unwritten results, and forces the reset values. `rst` overrides all requests.

## Structure
- **Package `rf_arb_pkg`:**
  - `wb_req_t` struct {logic [4:0] rdi; logic [XLEN-1:0] rd;}
  - `wb_entry_t` (adds `kill`)
  - constant `REG_ZERO = 5'd0`
- **Sub-module `wb_fifo`:** circular queue with head/tail/count, a per-entry kill vector, squash-by-index input, and a live-mask output for `pending`.
- **Top level:** arbitration, `wait_cnt`, and the output registers.

## Test plan
- **ALU only:** ALU write x4 = 0x12345 in cycle 1 → `write_enable = 1`, `rdi = 4`, `rd = 0x12345` in cycle 2. After a register file readback, rs1 at `rsi1 = 4` reads 0x12345.
- **Starvation:**
  - stimulus: MD write x3 = 0x98765 while `alu_valid` stays high continuously
  - response: ALU wins 4 cycles, then `alu_stall = 1` for one cycle, then an x3 write of 0x98765 with `pending[3]` cleared
- **Squash:** MD x5 = 0xAAAA queued, then ALU x5 = 0xBBBB granted → the x5 entry is killed and popped silently. The final x5 value is 0xBBBB, only one write occurs, and `pending[5]` goes 1→0.
- **Full/backpressure (DEPTH=2):** two MD writes are queued under continuous ALU traffic → `md_ready = 0`. A third MD result is held until the first drain. Write order is preserved.
- **x0 and reset:**
  - ALU and MD writes to x0 → never `write_enable`, `pending = 0`
  - `rst` asserted with 2 entries queued → next cycle all outputs are at their reset values, and no queued write ever appears
